// File: rtl/tl_ul_pkg.sv
// Shared TileLink-UL definitions: opcodes, response-queue entry layout and decode helper.
package tl_ul_pkg;

  localparam logic [2:0] PUT_FULL        = 3'd0;
  localparam logic [2:0] PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] GET             = 3'd4;
  localparam logic [2:0] ACCESS_ACK      = 3'd0;
  localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

  // Entries carry the widest supported tag; the top zero-extends its SRC_W source into it.
  localparam int SRC_MAX_W  = 8;
  localparam int FIFO_DEPTH = 3;

  typedef struct packed {
    logic [2:0]           opcode;
    logic [1:0]           size;
    logic [SRC_MAX_W-1:0] source;
    logic                 denied;
    logic [31:0]          data;
  } resp_entry_t;

  function automatic logic is_supported(input logic [2:0] op);
    return (op == PUT_FULL) || (op == PUT_PARTIAL) || (op == GET);
  endfunction

endpackage

// File: rtl/tl_ul_resp_fifo.sv
// Three-entry in-order circular queue of D-channel responses.
module tl_ul_resp_fifo
  import tl_ul_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enq_valid,
  input  resp_entry_t enq_entry,
  output logic        deq_valid,
  input  logic        deq_ready,
  output resp_entry_t deq_entry,
  output logic [1:0]  count
);

  resp_entry_t mem_q [FIFO_DEPTH];
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [1:0]  count_q, count_d;
  logic        enq, deq;

  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign deq_valid = (count_q != 2'd0);
  assign deq       = deq_valid & deq_ready;
  // A full queue can still accept when the head leaves in the same cycle.
  assign enq       = enq_valid & ((count_q != 2'd3) | deq);
  assign deq_entry = mem_q[rd_ptr_q];
  assign count     = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq) wr_ptr_d = next_ptr(wr_ptr_q);
    if (deq) rd_ptr_d = next_ptr(rd_ptr_q);
    case ({enq, deq})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 2'd0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (enq) mem_q[wr_ptr_q] <= enq_entry;
    end
  end

endmodule

// File: rtl/tl_ul_sram_slave.sv
// TileLink-UL slave: decodes buffered A requests onto a synchronous SRAM and
// returns in-order D responses through a credit-limited three-entry queue.
module tl_ul_sram_slave
  import tl_ul_pkg::*;
#(
  parameter int          SRC_W  = 4,
  parameter int          ADDR_W = 10,
  parameter logic [31:0] BASE   = 32'h8000_0000
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [2:0]        a_opcode,
  input  logic [2:0]        a_param,
  input  logic [1:0]        a_size,
  input  logic [SRC_W-1:0]  a_source,
  input  logic [31:0]       a_address,
  input  logic [3:0]        a_mask,
  input  logic [31:0]       a_data,
  output logic              d_valid,
  input  logic              d_ready,
  output logic [2:0]        d_opcode,
  output logic [1:0]        d_param,
  output logic [1:0]        d_size,
  output logic [SRC_W-1:0]  d_source,
  output logic              d_denied,
  output logic              d_corrupt,
  output logic [31:0]       d_data,
  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [3:0]        sram_wmask,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata
);

  logic             accept, hit;
  logic [1:0]       fifo_count;
  logic             deq_valid;
  resp_entry_t      enq_entry, deq_entry;

  logic             s1_valid_q, s1_valid_d;
  logic [2:0]       s1_opcode_q, s1_opcode_d;
  logic [1:0]       s1_size_q, s1_size_d;
  logic [SRC_W-1:0] s1_source_q, s1_source_d;
  logic             s1_denied_q, s1_denied_d;
  logic             s1_is_read_q, s1_is_read_d;

  // Credits count both queued responses and the one still in s1, so the
  // queue can never overflow and d_ready never reaches a_ready combinationally.
  assign a_ready = ({1'b0, fifo_count} + {2'b00, s1_valid_q}) < 3'd3;
  assign accept  = a_valid & a_ready;
  assign hit     = (a_address[31:ADDR_W+2] == BASE[31:ADDR_W+2]) & is_supported(a_opcode);

  always_comb begin
    sram_en    = accept & hit;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wmask = 4'b0000;
    sram_wdata = 32'h0;
    if (sram_en) begin
      sram_we    = (a_opcode != GET);
      sram_addr  = a_address[ADDR_W+1:2];
      sram_wmask = a_mask;
      sram_wdata = a_data;
    end
  end

  always_comb begin
    s1_valid_d   = accept;
    s1_opcode_d  = s1_opcode_q;
    s1_size_d    = s1_size_q;
    s1_source_d  = s1_source_q;
    s1_denied_d  = s1_denied_q;
    s1_is_read_d = s1_is_read_q;
    if (accept) begin
      s1_opcode_d  = (a_opcode == GET) ? ACCESS_ACK_DATA : ACCESS_ACK;
      s1_size_d    = a_size;
      s1_source_d  = a_source;
      s1_denied_d  = ~hit;
      s1_is_read_d = (a_opcode == GET);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q   <= 1'b0;
      s1_opcode_q  <= 3'd0;
      s1_size_q    <= 2'd0;
      s1_source_q  <= '0;
      s1_denied_q  <= 1'b0;
      s1_is_read_q <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_opcode_q  <= s1_opcode_d;
      s1_size_q    <= s1_size_d;
      s1_source_q  <= s1_source_d;
      s1_denied_q  <= s1_denied_d;
      s1_is_read_q <= s1_is_read_d;
    end
  end

  // The macro presents read data only during the cycle after enable, so it is captured here.
  always_comb begin
    enq_entry        = '0;
    enq_entry.opcode = s1_opcode_q;
    enq_entry.size   = s1_size_q;
    enq_entry.source = SRC_MAX_W'(s1_source_q);
    enq_entry.denied = s1_denied_q;
    enq_entry.data   = (s1_is_read_q & ~s1_denied_q) ? sram_rdata : 32'h0;
  end

  tl_ul_resp_fifo u_resp_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .enq_valid (s1_valid_q),
    .enq_entry (enq_entry),
    .deq_valid (deq_valid),
    .deq_ready (d_ready),
    .deq_entry (deq_entry),
    .count     (fifo_count)
  );

  assign d_valid   = deq_valid;
  assign d_opcode  = deq_entry.opcode;
  assign d_param   = 2'b00;
  assign d_size    = deq_entry.size;
  assign d_source  = deq_entry.source[SRC_W-1:0];
  assign d_denied  = deq_entry.denied;
  assign d_corrupt = deq_entry.denied & (deq_entry.opcode == ACCESS_ACK_DATA);
  assign d_data    = deq_entry.data;

  logic unused_bits;
  assign unused_bits = ^{a_param, a_address[1:0], deq_entry.source};

endmodule

// File: tb/tb_tl_ul_sram_slave.sv
// Directed bench for tl_ul_sram_slave with a behavioural synchronous SRAM.
module tb_tl_ul_sram_slave;
  import tl_ul_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        a_valid, a_ready;
  logic [2:0]  a_opcode, a_param;
  logic [1:0]  a_size;
  logic [3:0]  a_source;
  logic [31:0] a_address, a_data;
  logic [3:0]  a_mask;
  logic        d_valid, d_ready;
  logic [2:0]  d_opcode;
  logic [1:0]  d_param, d_size;
  logic [3:0]  d_source;
  logic        d_denied, d_corrupt;
  logic [31:0] d_data;
  logic        sram_en, sram_we;
  logic [9:0]  sram_addr;
  logic [3:0]  sram_wmask;
  logic [31:0] sram_wdata, sram_rdata;

  typedef struct {
    int          cyc;
    logic [2:0]  op;
    logic [1:0]  size;
    logic [3:0]  src;
    logic        den;
    logic        cor;
    logic [31:0] data;
  } rec_t;

  rec_t        resp_q[$];
  int          acc_q[$];
  int          sramEnCnt = 0;
  int          cyc = 0;
  int          stallCycles = 0;
  int          tests = 0;
  int          fails = 0;
  logic [31:0] mem [1024];

  tl_ul_sram_slave #(.SRC_W(4), .ADDR_W(10), .BASE(32'h8000_0000)) dut (
    .clock(clock), .reset_n(reset_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
    .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
    .a_data(a_data),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
    .d_size(d_size), .d_source(d_source), .d_denied(d_denied), .d_corrupt(d_corrupt),
    .d_data(d_data),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wmask(sram_wmask), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Read data is valid only in the cycle after a read; otherwise it is garbage.
  always @(posedge clock) begin
    if (sram_en && sram_we) begin
      for (int b = 0; b < 4; b++)
        if (sram_wmask[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      sram_rdata <= 32'hBAD0_BAD0;
    end else if (sram_en) begin
      sram_rdata <= mem[sram_addr];
    end else begin
      sram_rdata <= 32'hBAD0_BAD0;
    end
  end

  always @(negedge clock) begin
    rec_t r;
    if (reset_n) begin
      if (d_valid && d_ready) begin
        r.cyc = cyc; r.op = d_opcode; r.size = d_size; r.src = d_source;
        r.den = d_denied; r.cor = d_corrupt; r.data = d_data;
        resp_q.push_back(r);
      end
      if (a_valid && a_ready) acc_q.push_back(cyc);
      if (sram_en) sramEnCnt++;
    end
  end

  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] addr,
                               input logic [3:0] mask, input logic [31:0] data,
                               input logic [3:0] src, input logic [1:0] size);
    int waitCnt = 0;
    a_valid = 1'b1; a_opcode = op; a_address = addr; a_mask = mask;
    a_data = data; a_source = src; a_size = size; a_param = 3'd0;
    while (!a_ready && waitCnt < 50) begin
      @(posedge clock); #1;
      waitCnt++;
    end
    stallCycles += waitCnt;
    if (a_ready) begin
      @(posedge clock); #1;
    end
    a_valid = 1'b0;
  endtask

  task automatic waitResp(input int target);
    int k = 0;
    while (resp_q.size() < target && k < 60) begin
      @(posedge clock); #1;
      k++;
    end
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    #3;
    tests++; if (d_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset d_valid: got %b expected 0", d_valid); end
    tests++; if (a_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset a_ready: got %b expected 1", a_ready); end
    tests++; if (sram_en !== 1'b0 || sram_we !== 1'b0) begin fails++; $display("[TB] FAIL reset sram_en/we: got %b/%b expected 0/0", sram_en, sram_we); end
    tests++; if (d_data !== 32'h0 || d_source !== 4'h0 || d_opcode !== 3'd0) begin fails++; $display("[TB] FAIL reset d fields: data %h src %h op %h expected zeros", d_data, d_source, d_opcode); end
    tests++; if (sram_addr !== 10'h0 || sram_wdata !== 32'h0) begin fails++; $display("[TB] FAIL reset sram bus: addr %h wdata %h expected zeros", sram_addr, sram_wdata); end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_put_get;
    int rb = resp_q.size(), ab = acc_q.size(), eb = sramEnCnt;
    d_ready = 1'b1;
    applyStimulus(PUT_FULL, 32'h8000_0010, 4'hF, 32'hDEAD_BEEF, 4'd1, 2'd2);
    applyStimulus(GET,      32'h8000_0010, 4'hF, 32'h0,        4'd2, 2'd2);
    waitResp(rb + 2);
    tests++; if (resp_q.size() - rb !== 2) begin fails++; $display("[TB] FAIL put_get count: got %0d expected 2", resp_q.size() - rb); end
    else begin
      tests++; if (resp_q[rb].op !== ACCESS_ACK || resp_q[rb].den !== 1'b0 || resp_q[rb].data !== 32'h0) begin fails++; $display("[TB] FAIL put_get ack: op %0d den %b data %h expected 0 0 0", resp_q[rb].op, resp_q[rb].den, resp_q[rb].data); end
      tests++; if (resp_q[rb].cyc - acc_q[ab] !== 2) begin fails++; $display("[TB] FAIL put_get latency: got %0d expected 2", resp_q[rb].cyc - acc_q[ab]); end
      tests++; if (resp_q[rb+1].op !== ACCESS_ACK_DATA || resp_q[rb+1].data !== 32'hDEAD_BEEF) begin fails++; $display("[TB] FAIL put_get read: op %0d data %h expected 1 deadbeef", resp_q[rb+1].op, resp_q[rb+1].data); end
      tests++; if (resp_q[rb+1].src !== 4'd2 || resp_q[rb+1].cor !== 1'b0 || resp_q[rb+1].size !== 2'd2) begin fails++; $display("[TB] FAIL put_get tags: src %0d cor %b size %0d expected 2 0 2", resp_q[rb+1].src, resp_q[rb+1].cor, resp_q[rb+1].size); end
    end
    tests++; if (sramEnCnt - eb !== 2) begin fails++; $display("[TB] FAIL put_get sram_en count: got %0d expected 2", sramEnCnt - eb); end
    tests++; if (mem[4] !== 32'hDEAD_BEEF) begin fails++; $display("[TB] FAIL put_get sram word: got %h expected deadbeef", mem[4]); end
  endtask

  task automatic test_partial;
    int rb = resp_q.size(), eb = sramEnCnt;
    applyStimulus(PUT_PARTIAL, 32'h8000_0010, 4'b0010, 32'h0000_AB00, 4'd1, 2'd2);
    applyStimulus(GET,         32'h8000_0010, 4'hF,    32'h0,        4'd2, 2'd2);
    applyStimulus(PUT_PARTIAL, 32'h8000_0010, 4'b0000, 32'hFFFF_FFFF, 4'd3, 2'd2);
    applyStimulus(GET,         32'h8000_0010, 4'hF,    32'h0,        4'd4, 2'd2);
    waitResp(rb + 4);
    tests++; if (resp_q.size() - rb !== 4) begin fails++; $display("[TB] FAIL partial count: got %0d expected 4", resp_q.size() - rb); end
    else begin
      tests++; if (resp_q[rb+1].data !== 32'hDEAD_ABEF) begin fails++; $display("[TB] FAIL partial merge: got %h expected deadabef", resp_q[rb+1].data); end
      tests++; if (resp_q[rb+2].op !== ACCESS_ACK || resp_q[rb+2].den !== 1'b0) begin fails++; $display("[TB] FAIL partial mask0 ack: op %0d den %b expected 0 0", resp_q[rb+2].op, resp_q[rb+2].den); end
      tests++; if (resp_q[rb+3].data !== 32'hDEAD_ABEF) begin fails++; $display("[TB] FAIL partial mask0 read: got %h expected deadabef", resp_q[rb+3].data); end
    end
    tests++; if (sramEnCnt - eb !== 4) begin fails++; $display("[TB] FAIL partial sram_en count: got %0d expected 4", sramEnCnt - eb); end
  endtask

  task automatic test_denied;
    int rb = resp_q.size(), eb = sramEnCnt;
    applyStimulus(GET,  32'h0000_0000, 4'hF, 32'h0,         4'd3, 2'd2);
    applyStimulus(3'd2, 32'h8000_0000, 4'hF, 32'h1234_5678, 4'd4, 2'd1);
    applyStimulus(GET,  32'h8000_0FFC, 4'hF, 32'h0,         4'd5, 2'd2);
    applyStimulus(GET,  32'h8000_1000, 4'hF, 32'h0,         4'd6, 2'd2);
    waitResp(rb + 4);
    tests++; if (sramEnCnt - eb !== 1) begin fails++; $display("[TB] FAIL denied sram_en count: got %0d expected 1", sramEnCnt - eb); end
    tests++; if (resp_q.size() - rb !== 4) begin fails++; $display("[TB] FAIL denied count: got %0d expected 4", resp_q.size() - rb); end
    else begin
      tests++; if (resp_q[rb].op !== ACCESS_ACK_DATA || resp_q[rb].den !== 1'b1 || resp_q[rb].cor !== 1'b1 || resp_q[rb].data !== 32'h0) begin fails++; $display("[TB] FAIL denied get: op %0d den %b cor %b data %h expected 1 1 1 0", resp_q[rb].op, resp_q[rb].den, resp_q[rb].cor, resp_q[rb].data); end
      tests++; if (resp_q[rb+1].op !== ACCESS_ACK || resp_q[rb+1].den !== 1'b1 || resp_q[rb+1].cor !== 1'b0 || resp_q[rb+1].data !== 32'h0 || resp_q[rb+1].size !== 2'd1) begin fails++; $display("[TB] FAIL denied opcode2: op %0d den %b cor %b data %h size %0d expected 0 1 0 0 1", resp_q[rb+1].op, resp_q[rb+1].den, resp_q[rb+1].cor, resp_q[rb+1].data, resp_q[rb+1].size); end
      tests++; if (resp_q[rb+2].den !== 1'b0 || resp_q[rb+2].op !== ACCESS_ACK_DATA) begin fails++; $display("[TB] FAIL denied top word: den %b op %0d expected 0 1", resp_q[rb+2].den, resp_q[rb+2].op); end
      tests++; if (resp_q[rb+3].den !== 1'b1 || resp_q[rb+3].cor !== 1'b1 || resp_q[rb+3].src !== 4'd6) begin fails++; $display("[TB] FAIL denied past end: den %b cor %b src %0d expected 1 1 6", resp_q[rb+3].den, resp_q[rb+3].cor, resp_q[rb+3].src); end
    end
  endtask

  task automatic test_backpressure;
    int rb = resp_q.size(), ab = acc_q.size();
    int idx = 0;
    logic readyNow;
    d_ready = 1'b0;
    a_opcode = GET; a_address = 32'h8000_0010; a_mask = 4'hF; a_size = 2'd2;
    a_data = 32'h0; a_source = 4'd0; a_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      readyNow = a_ready;
      @(posedge clock); #1;
      if (readyNow) begin idx++; a_source = idx[3:0]; end
    end
    tests++; if (acc_q.size() - ab !== 3) begin fails++; $display("[TB] FAIL backpressure accepted: got %0d expected 3", acc_q.size() - ab); end
    tests++; if (a_ready !== 1'b0) begin fails++; $display("[TB] FAIL backpressure a_ready: got %b expected 0", a_ready); end
    tests++; if (d_valid !== 1'b1 || d_source !== 4'd0 || resp_q.size() !== rb) begin fails++; $display("[TB] FAIL backpressure hold: d_valid %b src %0d resp %0d expected 1 0 0", d_valid, d_source, resp_q.size() - rb); end
    d_ready = 1'b1;
    for (int c = 0; c < 20 && idx < 5; c++) begin
      readyNow = a_ready;
      @(posedge clock); #1;
      if (readyNow) begin
        idx++;
        if (idx == 5) a_valid = 1'b0; else a_source = idx[3:0];
      end
    end
    a_valid = 1'b0;
    waitResp(rb + 5);
    tests++; if (resp_q.size() - rb !== 5 || acc_q.size() - ab !== 5) begin fails++; $display("[TB] FAIL backpressure totals: resp %0d acc %0d expected 5 5", resp_q.size() - rb, acc_q.size() - ab); end
    else begin
      for (int i = 0; i < 5; i++) begin
        tests++; if (resp_q[rb+i].src !== i[3:0] || resp_q[rb+i].data !== 32'hDEAD_ABEF) begin fails++; $display("[TB] FAIL backpressure order %0d: src %0d data %h expected %0d deadabef", i, resp_q[rb+i].src, resp_q[rb+i].data, i); end
      end
      tests++; if (!(resp_q[rb].cyc < acc_q[ab+3])) begin fails++; $display("[TB] FAIL backpressure credit: first resp cyc %0d fourth accept cyc %0d expected resp earlier", resp_q[rb].cyc, acc_q[ab+3]); end
    end
  endtask

  task automatic test_back_to_back;
    int rb = resp_q.size(), ab = acc_q.size(), sb = stallCycles;
    d_ready = 1'b1;
    for (int i = 0; i < 8; i++)
      applyStimulus(GET, 32'h8000_0010, 4'hF, 32'h0, i[3:0], 2'd2);
    waitResp(rb + 8);
    tests++; if (stallCycles - sb !== 0) begin fails++; $display("[TB] FAIL back_to_back stalls: got %0d expected 0", stallCycles - sb); end
    tests++; if (resp_q.size() - rb !== 8) begin fails++; $display("[TB] FAIL back_to_back count: got %0d expected 8", resp_q.size() - rb); end
    else begin
      for (int i = 0; i < 8; i++) begin
        tests++; if (resp_q[rb+i].src !== i[3:0] || resp_q[rb+i].cyc !== acc_q[ab] + 2 + i || resp_q[rb+i].data !== 32'hDEAD_ABEF) begin fails++; $display("[TB] FAIL back_to_back resp %0d: src %0d cyc %0d data %h expected %0d %0d deadabef", i, resp_q[rb+i].src, resp_q[rb+i].cyc, resp_q[rb+i].data, i, acc_q[ab] + 2 + i); end
      end
    end
  endtask

  task automatic test_reset_mid;
    int rb = resp_q.size();
    d_ready = 1'b0;
    applyStimulus(GET, 32'h8000_0010, 4'hF, 32'h0, 4'd10, 2'd2);
    applyStimulus(GET, 32'h8000_0010, 4'hF, 32'h0, 4'd11, 2'd2);
    applyStimulus(GET, 32'h8000_0010, 4'hF, 32'h0, 4'd12, 2'd2);
    tests++; if (d_valid !== 1'b1 || d_source !== 4'd10) begin fails++; $display("[TB] FAIL reset_mid preload: d_valid %b src %0d expected 1 10", d_valid, d_source); end
    #2;
    reset_n = 1'b0;
    #1;
    tests++; if (d_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_mid async d_valid: got %b expected 0", d_valid); end
    tests++; if (a_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_mid a_ready: got %b expected 1", a_ready); end
    @(negedge clock);
    reset_n = 1'b1;
    d_ready = 1'b1;
    repeat (8) @(posedge clock);
    #1;
    tests++; if (resp_q.size() !== rb || d_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_mid stale: resp %0d d_valid %b expected 0 0", resp_q.size() - rb, d_valid); end
    applyStimulus(GET, 32'h8000_0010, 4'hF, 32'h0, 4'd9, 2'd2);
    waitResp(rb + 1);
    tests++; if (resp_q.size() - rb !== 1) begin fails++; $display("[TB] FAIL reset_mid after count: got %0d expected 1", resp_q.size() - rb); end
    else begin
      tests++; if (resp_q[rb].src !== 4'd9 || resp_q[rb].data !== 32'hDEAD_ABEF) begin fails++; $display("[TB] FAIL reset_mid after resp: src %0d data %h expected 9 deadabef", resp_q[rb].src, resp_q[rb].data); end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    a_valid = 1'b0; a_opcode = 3'd0; a_param = 3'd0; a_size = 2'd0; a_source = 4'd0;
    a_address = 32'h0; a_mask = 4'h0; a_data = 32'h0; d_ready = 1'b1; reset_n = 1'b0;
    test_reset();
    test_put_get();
    test_partial();
    test_denied();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tl_ul_sram_slave.md
Name: tl_ul_sram_slave

Overview:
- TileLink-UL slave endpoint that sits directly downstream of the A/D channel buffer pair.
- Consumes buffered A-channel requests (Get, PutFullData, PutPartialData) and drives an external single-port synchronous SRAM macro.
- Returns in-order D-channel responses through a 3-entry response FIFO.
- Address decode failures and unsupported opcodes get a denied response; they never touch the SRAM.

Parameters:
- SRC_W, 4, width of a_source/d_source.
- ADDR_W, 10, SRAM word-address width (depth = 2^ADDR_W 32-bit words).
- BASE, 32'h8000_0000, base byte address; must be aligned to 2^(ADDR_W+2).

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- a_valid  in  1  A request valid.
- a_ready  out  1  A request accepted when a_valid & a_ready.
- a_opcode  in  3  0 PutFull, 1 PutPartial, 4 Get; others unsupported.
- a_param  in  3  ignored.
- a_size  in  2  log2 bytes, 0..2.
- a_source  in  SRC_W  requester tag.
- a_address  in  32  byte address.
- a_mask  in  4  byte lanes.
- a_data  in  32  write data.
- d_valid  out  1  response valid.
- d_ready  in  1  response consumed when d_valid & d_ready.
- d_opcode  out  3  0 AccessAck, 1 AccessAckData.
- d_param  out  2  always 0.
- d_size  out  2  echo of a_size.
- d_source  out  SRC_W  echo of a_source.
- d_denied  out  1  decode or opcode error.
- d_corrupt  out  1  set with d_denied on AccessAckData.
- d_data  out  32  read data; 0 on denied or AccessAck.
- sram_en  out  1  macro enable.
- sram_we  out  1  write enable.
- sram_addr  out  ADDR_W  word address = a_address[ADDR_W+1:2].
- sram_wmask  out  4  byte write mask.
- sram_wdata  out  32  write data.
- sram_rdata  in  32  valid the cycle after a read enable; not held.

Behaviour:
- Reset (async assert, sync deassert handled upstream): s1_valid=0, FIFO empty, d_valid=0, sram_en=0, sram_we=0.
  - All other outputs are 0 until first use.
  - Assertion mid-operation discards in-flight requests and queued responses without producing any response.
- Accept rule: a_ready = (fifo_count + s1_valid) < 3. There is no combinational path from d_ready to a_ready.
- Decode: hit = (a_address[31:ADDR_W+2] == BASE[31:ADDR_W+2]) & opcode in {0,1,4}. Misaligned or size>2 is the upstream's responsibility and is not checked.
- Accept cycle n, hit:
  - sram_en=1, sram_we=(opcode!=4), sram_wmask=a_mask, sram_wdata=a_data.
  - A PutPartial with mask 0 still asserts sram_en with wmask 0.
- Accept cycle n, miss: no SRAM access. Only the tags and denied=1 are captured.
- When not accepting: sram_en=0.
- s1 register at cycle n+1 holds opcode-derived response type, size, source, denied, is_read. sram_rdata is sampled into the FIFO entry at the end of n+1 if s1 is a non-denied Get.
- FIFO: 3 entries, in order. Enqueue from s1 every cycle s1_valid=1; it never blocks, by construction of the credit rule. Dequeue when d_valid & d_ready. Simultaneous enqueue and dequeue is legal at any occupancy, including empty→pass-through of head at n+2 (no bypass).
- Latency: d_valid earliest at n+2. Sustained throughput is 1 request/cycle with d_ready held high.
- Ordering: a write at cycle n followed by a read of the same address at n+1 returns the new data, via the synchronous SRAM write-first-then-read timing.
- d_data is forced to 0 for AccessAck and for denied responses. d_corrupt = d_denied & (d_opcode==1).
- d outputs are held stable while d_valid & !d_ready.

Decomposition:
- Shared package tl_ul_pkg:
  - opcode constants (PUT_FULL=0, PUT_PARTIAL=1, GET=4, ACCESS_ACK=0, ACCESS_ACK_DATA=1).
  - response-entry struct {opcode[2:0], size[1:0], source, denied, data[31:0]}.
- One sub-module: tl_ul_resp_fifo, a 3-entry circular FIFO.
  - Pointer wrap at 3, count 0..3.
  - Ports enq_valid/enq_entry, deq_valid/deq_ready/deq_entry, count.

Test Plan:
- PutFull addr 0x8000_0010 data 0xDEADBEEF mask F, then Get same addr → AccessAck (denied 0) at n+2, then AccessAckData data 0xDEADBEEF.
- PutPartial mask 4'b0010 data 0x0000_AB00 over 0xDEADBEEF, then Get → data 0xDEADABEF.
- Get addr 0x0000_0000 (out of range) and opcode 2 at 0x8000_0000 → no sram_en; responses with d_denied=1, d_corrupt=1 for the Get, d_data 0, d_corrupt=0 for the opcode-2 AccessAck.
- d_ready=0 with 5 back-to-back Gets → exactly 3 accepted, a_ready falls; raising d_ready drains 3 responses in source order 0,1,2, then accepts the remaining two.
- d_ready=1 with 8 back-to-back Gets sources 0..7 → a_ready stays 1, 8 responses on consecutive cycles starting n+2.
- reset_n low with 2 responses queued and one in s1 → d_valid=0 immediately (async); after release, a_ready=1 and no stale response appears.
